// File: rtl/projector_sequencer.sv
// projector_sequencer: accepts whole triangles over valid/ready, serializes
// them one vertex per cycle into ddd_projector, throttles issue against a
// credit count for the rasterizer FIFO, and closes each frame with a
// done/done_out exchange before pulsing frame_done.
module projector_sequencer #(
    parameter int MAX_CREDITS = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         frame_start,
    input  logic         tri_valid,
    output logic         tri_ready,
    input  logic [143:0] tri_vertices,
    input  logic [15:0]  tri_color,
    input  logic         tri_last,
    output logic [47:0]  vertex,
    output logic [15:0]  color,
    output logic         new_triangle,
    output logic         done,
    input  logic         proj_done,
    input  logic         credit_return,
    output logic         busy,
    output logic         frame_done,
    output logic [15:0]  tri_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_V1,
        S_V2,
        S_V3,
        S_FLUSH,
        S_DRAIN
    } state_t;

    localparam logic [7:0] CREDIT_MAX = 8'(MAX_CREDITS);

    state_t       state;
    state_t       next_state;
    logic [7:0]   credits;
    logic [143:0] held_vertices;
    logic [15:0]  held_color;
    logic         held_last;
    logic         accept;

    // Saturating triangle counter increment (sticks at all-ones).
    function automatic logic [15:0] sat_inc16(input logic [15:0] val);
        return (val == 16'hFFFF) ? val : val + 16'd1;
    endfunction

    // Credit increment that drops returns beyond the FIFO depth.
    function automatic logic [7:0] credit_inc(input logic [7:0] val);
        return (val >= CREDIT_MAX) ? CREDIT_MAX : val + 8'd1;
    endfunction

    // Ready depends only on registered state so upstream sees no comb loop.
    assign tri_ready = ((state == S_WAIT) || (state == S_V3 && !held_last))
                       && (credits != 8'd0);
    assign accept    = tri_valid && tri_ready;
    assign busy      = (state != S_IDLE);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    // Next-state decode.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (frame_start) next_state = S_WAIT;
            S_WAIT:  if (accept) next_state = S_V1;
            S_V1:    next_state = S_V2;
            S_V2:    next_state = S_V3;
            S_V3: begin
                if (accept)         next_state = S_V1;
                else if (held_last) next_state = S_FLUSH;
                else                next_state = S_WAIT;
            end
            S_FLUSH: next_state = S_DRAIN;
            S_DRAIN: if (proj_done) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Triangle hold registers; pure data, loaded only on accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            held_vertices <= tri_vertices;
            held_color    <= tri_color;
        end
    end

    // Last-of-frame flag steers V3 and gates ready, so it is reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         held_last <= 1'b0;
        else if (accept) held_last <= tri_last;
    end

    // Projector outputs, registered from the state being entered.
    // V1 is only entered on accept, so v1 comes straight from the input bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vertex       <= '0;
            color        <= '0;
            new_triangle <= 1'b0;
            done         <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            vertex       <= '0;
            color        <= '0;
            new_triangle <= 1'b0;
            case (next_state)
                S_V1: begin
                    vertex       <= tri_vertices[143:96];
                    color        <= tri_color;
                    new_triangle <= 1'b1;
                end
                S_V2: begin
                    vertex <= held_vertices[95:48];
                    color  <= held_color;
                end
                S_V3: begin
                    vertex <= held_vertices[47:0];
                    color  <= held_color;
                end
                default: ;
            endcase
            done       <= (next_state == S_FLUSH);
            frame_done <= (state == S_DRAIN) && proj_done;
        end
    end

    // Credit counter: accept and return in the same cycle cancel out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credits <= CREDIT_MAX;
        end else begin
            case ({accept, credit_return})
                2'b10:   credits <= credits - 8'd1;
                2'b01:   credits <= credit_inc(credits);
                default: credits <= credits;
            endcase
        end
    end

    // Per-frame issued-triangle count, cleared when a frame is started.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                               tri_count <= '0;
        else if (state == S_IDLE && frame_start) tri_count <= '0;
        else if (accept)                       tri_count <= sat_inc16(tri_count);
    end

endmodule

// File: tb/tb_projector_sequencer.sv
// Directed bench for projector_sequencer with a vertex scoreboard and a
// small projector model answering done with done_out 18 cycles later.
module tb_projector_sequencer;

    localparam int MAXC = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         frame_start = 1'b0;
    logic         tri_valid = 1'b0;
    logic         tri_ready;
    logic [143:0] tri_vertices = '0;
    logic [15:0]  tri_color = '0;
    logic         tri_last = 1'b0;
    logic [47:0]  vertex;
    logic [15:0]  color;
    logic         new_triangle;
    logic         done;
    logic         proj_done = 1'b0;
    logic         credit_return = 1'b0;
    logic         busy;
    logic         frame_done;
    logic [15:0]  tri_count;

    projector_sequencer #(.MAX_CREDITS(MAXC)) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start),
        .tri_valid(tri_valid), .tri_ready(tri_ready),
        .tri_vertices(tri_vertices), .tri_color(tri_color), .tri_last(tri_last),
        .vertex(vertex), .color(color), .new_triangle(new_triangle),
        .done(done), .proj_done(proj_done), .credit_return(credit_return),
        .busy(busy), .frame_done(frame_done), .tri_count(tri_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [64:0] exp_q[$];
    int          nt_cyc[$];
    int          fd_count = 0;
    int          phase = 0;
    logic [64:0] mon_e;

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Scoreboard: each new_triangle opens a 3-cycle window of expected vertices.
    always @(negedge clk) begin
        if (rst) begin
            phase = 0;
        end else begin
            if (frame_done) fd_count++;
            if (new_triangle) begin
                nt_cyc.push_back(cyc);
                phase = 3;
            end
            if (phase > 0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_vertex", 80'({vertex, color, new_triangle}), 80'(0));
                end else begin
                    mon_e = exp_q.pop_front();
                    check("vertex_out", 80'({vertex, color, new_triangle}), 80'(mon_e));
                end
                phase--;
            end
        end
    end

    task automatic send_tri(input logic [143:0] v, input logic [15:0] c,
                            input logic last, input logic ret);
        tri_vertices = v;
        tri_color    = c;
        tri_last     = last;
        tri_valid    = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (tri_ready) begin
                credit_return = ret;
                exp_q.push_back({v[143:96], c, 1'b1});
                exp_q.push_back({v[95:48],  c, 1'b0});
                exp_q.push_back({v[47:0],   c, 1'b0});
                @(negedge clk);
                credit_return = 1'b0;
                tri_valid     = 1'b0;
                return;
            end
            @(negedge clk);
        end
        tri_valid = 1'b0;
        check("accept_timeout", 80'(0), 80'(1));
    endtask

    task automatic pulse_frame_start();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic pulse_return();
        credit_return = 1'b1;
        @(negedge clk);
        credit_return = 1'b0;
    endtask

    // Waits for done, then plays the projector: done_out 18 cycles after done.
    task automatic finish_frame(input int exp_wait, input logic poke);
        int w = 0;
        int fd0;
        while (!done && w < 30) begin
            @(negedge clk);
            w++;
        end
        if (exp_wait >= 0) check("done_latency", 80'(w), 80'(exp_wait));
        check("done_high", 80'(done), 80'(1));
        fd0 = fd_count;
        @(negedge clk);
        check("done_one_cycle", 80'(done), 80'(0));
        check("busy_drain", 80'(busy), 80'(1));
        if (poke) begin
            pulse_frame_start();
            repeat (16) @(negedge clk);
        end else begin
            repeat (17) @(negedge clk);
        end
        check("frame_done_early", 80'(frame_done), 80'(0));
        proj_done = 1'b1;
        @(negedge clk);
        proj_done = 1'b0;
        check("frame_done", 80'(frame_done), 80'(1));
        @(negedge clk);
        check("frame_done_pulse", 80'(frame_done), 80'(0));
        check("idle_after_frame", 80'(busy), 80'(0));
        check("frame_done_count", 80'(fd_count - fd0), 80'(1));
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        check("rst_busy", 80'(busy), 80'(0));
        check("rst_ready", 80'(tri_ready), 80'(0));
        check("rst_outs", 80'({vertex, color, new_triangle, done, frame_done}), 80'(0));
        check("rst_count", 80'(tri_count), 80'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_ready", 80'(tri_ready), 80'(0));

        // Single-triangle frame
        pulse_frame_start();
        check("wait_busy", 80'(busy), 80'(1));
        check("wait_ready", 80'(tri_ready), 80'(1));
        send_tri({48'h0001_0002_0040, 48'hFFFD_0004_0040, 48'h0005_FFFA_0080},
                 16'hBEEF, 1'b1, 1'b0);
        check("v1_literal", 80'(vertex), 80'(48'h0001_0002_0040));
        finish_frame(3, 1'b0);
        check("count_single", 80'(tri_count), 80'(1));
        pulse_return();

        // Back-to-back; frame_start poked during DRAIN must be ignored
        nt_cyc.delete();
        pulse_frame_start();
        send_tri({48'h0010_0011_0012, 48'h0013_0014_0015, 48'h0016_0017_0018}, 16'h1111, 1'b0, 1'b1);
        send_tri({48'h0020_0021_0022, 48'h0023_0024_0025, 48'h0026_0027_0028}, 16'h2222, 1'b0, 1'b1);
        send_tri({48'h0030_0031_0032, 48'h0033_0034_0035, 48'h0036_0037_0038}, 16'h3333, 1'b1, 1'b1);
        finish_frame(3, 1'b1);
        check("b2b_pulses", 80'(nt_cyc.size()), 80'(3));
        if (nt_cyc.size() == 3) begin
            check("b2b_gap1", 80'(nt_cyc[1] - nt_cyc[0]), 80'(3));
            check("b2b_gap2", 80'(nt_cyc[2] - nt_cyc[1]), 80'(3));
        end
        check("count_b2b_kept", 80'(tri_count), 80'(3));

        // Spurious returns at full credits, then exhaustion
        repeat (10) pulse_return();
        pulse_frame_start();
        send_tri({48'h0100_0101_0102, 48'h0103_0104_0105, 48'h0106_0107_0108}, 16'hA0A0, 1'b0, 1'b0);
        send_tri({48'h0200_0201_0202, 48'h0203_0204_0205, 48'h0206_0207_0208}, 16'hB0B0, 1'b0, 1'b0);
        begin
            logic seen;
            seen = 1'b0;
            tri_vertices = {48'h0300_0301_0302, 48'h0303_0304_0305, 48'h0306_0307_0308};
            tri_color    = 16'hC0C0;
            tri_last     = 1'b0;
            tri_valid    = 1'b1;
            repeat (8) begin
                seen = seen | tri_ready;
                @(negedge clk);
            end
            check("exhaust_ready", 80'(seen), 80'(0));
            credit_return = 1'b1;
            check("ready_no_comb_path", 80'(tri_ready), 80'(0));
            @(negedge clk);
            credit_return = 1'b0;
            check("ready_after_return", 80'(tri_ready), 80'(1));
        end
        send_tri({48'h0300_0301_0302, 48'h0303_0304_0305, 48'h0306_0307_0308}, 16'hC0C0, 1'b0, 1'b0);
        pulse_return();
        send_tri({48'h0400_0401_0402, 48'h0403_0404_0405, 48'h0406_0407_0408}, 16'hD0D0, 1'b1, 1'b1);
        finish_frame(-1, 1'b0);
        check("count_exhaust", 80'(tri_count), 80'(4));

        // Credits must be exactly 1 after the simultaneous accept/return
        pulse_frame_start();
        check("one_credit_ready", 80'(tri_ready), 80'(1));
        send_tri({48'h0500_0501_0502, 48'h0503_0504_0505, 48'h0506_0507_0508}, 16'hE0E0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("v3_no_credit", 80'(tri_ready), 80'(0));
        @(negedge clk);
        check("wait_no_credit", 80'({busy, tri_ready}), 80'(2'b10));
        pulse_return();
        send_tri({48'h0600_0601_0602, 48'h0603_0604_0605, 48'h0606_0607_0608}, 16'hF0F0, 1'b1, 1'b0);
        finish_frame(-1, 1'b0);
        check("count_credit1", 80'(tri_count), 80'(2));

        // Reset in the middle of V2
        pulse_return();
        pulse_frame_start();
        send_tri({48'h0700_0701_0702, 48'h0703_0704_0705, 48'h0706_0707_0708}, 16'h7777, 1'b0, 1'b0);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst_outs", 80'({vertex, color, new_triangle, done, frame_done}), 80'(0));
        check("midrst_ctrl", 80'({busy, tri_ready}), 80'(0));
        check("midrst_count", 80'(tri_count), 80'(0));
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        pulse_frame_start();
        send_tri({48'h0800_0801_0802, 48'h0803_0804_0805, 48'h0806_0807_0808}, 16'h8888, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("post_rst_credit", 80'(tri_ready), 80'(1));
        send_tri({48'h0900_0901_0902, 48'h0903_0904_0905, 48'h0906_0907_0908}, 16'h9999, 1'b1, 1'b0);
        finish_frame(-1, 1'b0);
        check("count_post_rst", 80'(tri_count), 80'(2));
        check("scoreboard_empty", 80'(exp_q.size()), 80'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
